gcd_unit: RTL
=============

GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 4..64.
REQ-002 Parameter BINARY, default 0: 0 selects subtractive Euclid; 1 selects binary (Stein) algorithm.
REQ-003 Parameter ITER_W, default 8: width of the iteration counter, legal range 4..16.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  request strobe; sampled only while ready=1.
REQ-007 in1  input  WIDTH  operand A, unsigned.
REQ-008 in2  input  WIDTH  operand B, unsigned.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high only in CALC.
REQ-011 done  output  1  one-cycle pulse, high only in DONE.
REQ-012 out  output  WIDTH  gcd(in1,in2); held from DONE entry until the next accepted start.
REQ-013 iters  output  ITER_W  count of CALC edges used by the last operation; held like out.

Function
REQ-014 Three states: IDLE, CALC, DONE; DONE always returns to IDLE on the next edge.
REQ-015 Accept = start&ready at an edge: capture in1/in2 into internal registers A/B, clear internal shift count k, clear iters.
REQ-016 At accept, if in1=0 or in2=0: go directly to DONE with out=in1|in2 and iters=0; gcd(0,0)=0.
REQ-017 Otherwise go to CALC; each CALC edge performs exactly one step and increments iters, saturating at 2^ITER_W-1 (no wrap).
REQ-018 Subtractive step (BINARY=0): A=B -> out=A, go DONE; A>B -> A=A-B; A<B -> B=B-A.
REQ-019 Binary step (BINARY=1), priority order: A=B -> out=A<<k, go DONE; A,B both even -> both shifted right 1, k+1; A even -> A>>1; B even -> B>>1; else subtract smaller from larger.
REQ-020 k is ceil(log2(WIDTH))+1 bits wide; A<<k is truncated to WIDTH bits, which never loses bits for a legal result.
REQ-021 All arithmetic is unsigned WIDTH-bit; subtraction is only performed larger-minus-smaller, so no borrow occurs.
REQ-022 Latency: done is high in the cycle after the Nth edge following the accept edge, N = iters (N=0 for zero operands).
REQ-023 start while busy or in DONE is ignored; no queuing, no error flag.
REQ-024 in1/in2 changes after the accept edge have no effect on the running operation.
REQ-025 out and iters are updated only on DONE entry; they never show intermediate values.

Reset
REQ-026 rst=1 at an edge forces IDLE, out=0, iters=0, done=0, busy=0, ready=1, and clears A, B and k; this takes priority over start.
REQ-027 Reset during CALC aborts the operation; no done pulse is produced for it.
REQ-028 The first start accepted after rst deasserts behaves as a fresh operation.

Verification
REQ-029 BINARY=0, in1=12, in2=18, start 1 cycle -> out=6, iters=3, done high for exactly 1 cycle after the 3rd post-accept edge.
REQ-030 BINARY=1, in1=12, in2=18 -> out=6, iters=5; in1=48, in2=180 -> out=12.
REQ-031 in1=0, in2=7 -> out=7, iters=0; in1=0, in2=0 -> out=0; in both cases done is high the cycle after the accept edge.
REQ-032 BINARY=0, ITER_W=4, in1=1, in2=40 -> out=1, iters saturates at 15; second start pulse mid-CALC ignored, out unchanged until DONE.
REQ-033 rst asserted 2 cycles into CALC for (1000,3) -> next cycle ready=1, out=0, no done; new start (9,6) -> out=3.
REQ-034 Random sweep, both modes, WIDTH=8 and 32, 10k pairs -> out matches reference gcd, out never changes except on DONE entry, done never high 2 consecutive cycles.

Source files
------------

// File: rtl/gcd_unit.sv
// Multi-cycle GCD engine: subtractive Euclid (BINARY=0) or Stein's binary algorithm (BINARY=1).
// Each CALC cycle performs one reduction step; out/iters are loaded only when the result is final.
module gcd_unit #(
    parameter int WIDTH  = 32,
    parameter int BINARY = 0,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  out,
    output logic [ITER_W-1:0] iters
);

    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a, b, a_next, b_next, result;
    logic [K_W-1:0]    k, k_next;
    logic [ITER_W-1:0] cnt, cnt_inc;
    logic              accept, zero_op, equal;

    assign accept  = start && (state == IDLE);
    assign zero_op = (in1 == '0) || (in2 == '0);
    assign equal   = (a == b);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + ITER_W'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = zero_op ? DONE : CALC;
            CALC:    if (equal) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        busy  = (state == CALC);
        done  = (state == DONE);
    end

    // Single reduction step; always larger-minus-smaller so no borrow can occur.
    always_comb begin
        a_next = a;
        b_next = b;
        k_next = k;
        if (BINARY != 0) begin
            if (equal) begin
                a_next = a;
            end else if (!a[0] && !b[0]) begin
                a_next = a >> 1;
                b_next = b >> 1;
                k_next = k + K_W'(1);
            end else if (!a[0]) begin
                a_next = a >> 1;
            end else if (!b[0]) begin
                b_next = b >> 1;
            end else if (a > b) begin
                a_next = a - b;
            end else begin
                b_next = b - a;
            end
        end else begin
            if (a > b)      a_next = a - b;
            else if (a < b) b_next = b - a;
        end
    end

    always_comb begin
        result = a;
        if (BINARY != 0) result = a << k;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            k     <= '0;
            cnt   <= '0;
            out   <= '0;
            iters <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= in1;
                        b     <= in2;
                        k     <= '0;
                        cnt   <= '0;
                        iters <= '0;
                        if (zero_op) out <= in1 | in2;
                    end
                end
                CALC: begin
                    a   <= a_next;
                    b   <= b_next;
                    k   <= k_next;
                    cnt <= cnt_inc;
                    if (equal) begin
                        out   <= result;
                        iters <= cnt_inc;
                    end
                end
                default: begin
                    a <= a;
                end
            endcase
        end
    end

endmodule
